// File: rtl/secam_timing_pkg.sv
// rtl/secam_timing_pkg.sv - SECAM line/frame timing constants, window enum and line-class helper
package secam_timing_pkg;

    localparam int SAMPLE_W        = 12;
    localparam int LINE_W          = 10;

    localparam int CLK_PER_LINE    = 3072;
    localparam int LINES_PER_FRAME = 625;
    localparam int CARRIER_START   = 280;
    localparam int ACTIVE_START    = 500;
    localparam int ACTIVE_END      = 3000;
    localparam int VBLANK_A_END    = 23;
    localparam int VBLANK_B_START  = 310;
    localparam int VBLANK_B_END    = 336;

    typedef enum logic [1:0] {
        WIN_OFF,
        WIN_REST,
        WIN_ACTIVE
    } win_e;

    // Lines inside either vertical blanking band carry no chroma at all.
    function automatic logic line_has_chroma(input int line, input int a_end,
                                             input int b_start, input int b_end);
        return ((line >= a_end) && (line < b_start)) || (line >= b_end);
    endfunction

endpackage

// File: rtl/video_line_counter.sv
// rtl/video_line_counter.sv - free-running sample/line counters with wrap lookahead and newframe pulse
module video_line_counter
    import secam_timing_pkg::*;
#(
    parameter int CLK_PER_LINE    = secam_timing_pkg::CLK_PER_LINE,
    parameter int LINES_PER_FRAME = secam_timing_pkg::LINES_PER_FRAME
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic [LINE_W-1:0]   line_o,
    output logic [SAMPLE_W-1:0] sample_next_o,
    output logic [LINE_W-1:0]   line_next_o,
    output logic                line_wrap_o,
    output logic                frame_wrap_o,
    output logic                newframe_o
);

    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                newframe_q;
    logic                line_wrap, frame_wrap;

    // Wrap flags describe the coming edge so the parent can register decisions aligned with it.
    assign line_wrap  = (sample_q == SAMPLE_W'(CLK_PER_LINE - 1));
    assign frame_wrap = line_wrap && (line_q == LINE_W'(LINES_PER_FRAME - 1));

    always_comb begin
        sample_d = sample_q + SAMPLE_W'(1);
        line_d   = line_q;
        if (line_wrap) begin
            sample_d = '0;
            line_d   = frame_wrap ? '0 : line_q + LINE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q   <= '0;
            line_q     <= '0;
            newframe_q <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            line_q     <= line_d;
            newframe_q <= frame_wrap;
        end
    end

    assign sample_o      = sample_q;
    assign line_o        = line_q;
    assign sample_next_o = sample_d;
    assign line_next_o   = line_d;
    assign line_wrap_o   = line_wrap;
    assign frame_wrap_o  = frame_wrap;
    assign newframe_o    = newframe_q;

endmodule

// File: rtl/secam_line_sequencer.sv
// rtl/secam_line_sequencer.sv - SECAM chroma line sequencer: Db/Dr alternation, rest-carrier window, vblank gating
module secam_line_sequencer
    import secam_timing_pkg::*;
#(
    parameter int CLK_PER_LINE    = secam_timing_pkg::CLK_PER_LINE,
    parameter int LINES_PER_FRAME = secam_timing_pkg::LINES_PER_FRAME,
    parameter int CARRIER_START   = secam_timing_pkg::CARRIER_START,
    parameter int ACTIVE_START    = secam_timing_pkg::ACTIVE_START,
    parameter int ACTIVE_END      = secam_timing_pkg::ACTIVE_END,
    parameter int VBLANK_A_END    = secam_timing_pkg::VBLANK_A_END,
    parameter int VBLANK_B_START  = secam_timing_pkg::VBLANK_B_START,
    parameter int VBLANK_B_END    = secam_timing_pkg::VBLANK_B_END
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [7:0]   yuv_u_in,
    input  logic signed [7:0]   yuv_v_in,
    input  logic                resync,
    output logic [SAMPLE_W-1:0] sample_count,
    output logic [LINE_W-1:0]   line_count,
    output logic                newframe,
    output logic                even_line,
    output logic                enabled,
    output logic signed [7:0]   yuv_u,
    output logic signed [7:0]   yuv_v
);

    if (!((CARRIER_START < ACTIVE_START) && (ACTIVE_START < ACTIVE_END) &&
          (ACTIVE_END <= CLK_PER_LINE))) begin : g_bad_window
        $error("secam_line_sequencer: horizontal window parameters out of order");
    end
    if (!((VBLANK_A_END <= VBLANK_B_START) && (VBLANK_B_START <= VBLANK_B_END) &&
          (VBLANK_B_END <= LINES_PER_FRAME))) begin : g_bad_vblank
        $error("secam_line_sequencer: vertical blanking parameters out of order");
    end

    logic [SAMPLE_W-1:0] sample_next;
    logic [LINE_W-1:0]   line_next;
    logic                line_wrap, frame_wrap;

    video_line_counter #(
        .CLK_PER_LINE    (CLK_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_o      (sample_count),
        .line_o        (line_count),
        .sample_next_o (sample_next),
        .line_next_o   (line_next),
        .line_wrap_o   (line_wrap),
        .frame_wrap_o  (frame_wrap),
        .newframe_o    (newframe)
    );

    win_e               win_d;
    logic               even_q, even_d;
    logic               resync_q, resync_d;
    logic               enabled_q, enabled_d;
    logic signed [7:0]  u_q, u_d, v_q, v_d;

    // Window is decoded on the next counter value so it lines up with the registered counters.
    always_comb begin
        win_d = WIN_OFF;
        if (line_has_chroma(int'(line_next), VBLANK_A_END, VBLANK_B_START, VBLANK_B_END)) begin
            if ((int'(sample_next) >= CARRIER_START) && (int'(sample_next) < ACTIVE_START)) begin
                win_d = WIN_REST;
            end else if ((int'(sample_next) >= ACTIVE_START) &&
                         (int'(sample_next) < ACTIVE_END)) begin
                win_d = WIN_ACTIVE;
            end
        end
    end

    // A resync seen on the frame-wrap cycle itself applies to that same wrap.
    always_comb begin
        even_d    = even_q;
        resync_d  = resync_q | resync;
        if (line_wrap) begin
            even_d = ~even_q;
        end
        if (frame_wrap) begin
            resync_d = 1'b0;
            if (resync_q || resync) begin
                even_d = 1'b1;
            end
        end
        enabled_d = (win_d != WIN_OFF);
        u_d       = (win_d == WIN_ACTIVE) ? yuv_u_in : 8'sd0;
        v_d       = (win_d == WIN_ACTIVE) ? yuv_v_in : 8'sd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            even_q    <= 1'b1;
            resync_q  <= 1'b0;
            enabled_q <= 1'b0;
            u_q       <= '0;
            v_q       <= '0;
        end else begin
            even_q    <= even_d;
            resync_q  <= resync_d;
            enabled_q <= enabled_d;
            u_q       <= u_d;
            v_q       <= v_d;
        end
    end

    assign even_line = even_q;
    assign enabled   = enabled_q;
    assign yuv_u     = u_q;
    assign yuv_v     = v_q;

endmodule

// File: tb/tb_secam_line_sequencer.sv
// tb/tb_secam_line_sequencer.sv - randomized self-checking bench for secam_line_sequencer against a timeline model
module tb_secam_line_sequencer;

    localparam int CPL   = 24;
    localparam int LPF   = 625;
    localparam int CS    = 4;
    localparam int AS    = 9;
    localparam int AE    = 21;
    localparam int VA    = 23;
    localparam int VBS   = 310;
    localparam int VBE   = 336;
    localparam int FRAME = CPL * LPF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] u_in, v_in;
    logic              rs_in;
    logic [11:0]       sample_count;
    logic [9:0]        line_count;
    logic              newframe, even_line, enabled;
    logic signed [7:0] yuv_u, yuv_v;

    secam_line_sequencer #(
        .CLK_PER_LINE(CPL), .LINES_PER_FRAME(LPF), .CARRIER_START(CS),
        .ACTIVE_START(AS), .ACTIVE_END(AE), .VBLANK_A_END(VA),
        .VBLANK_B_START(VBS), .VBLANK_B_END(VBE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .yuv_u_in(u_in), .yuv_v_in(v_in), .resync(rs_in),
        .sample_count(sample_count), .line_count(line_count), .newframe(newframe),
        .even_line(even_line), .enabled(enabled), .yuv_u(yuv_u), .yuv_v(yuv_v)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: absolute time t since reset, line parity measured from the last Db anchor line.
    int t       = 0;
    int anchor  = 0;
    bit pending = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step(input bit do_reset, input bit rs, input logic signed [7:0] u,
                        input logic signed [7:0] v);
        int  tl, ln, s;
        bit  chroma;
        rst_n = !do_reset;
        rs_in = rs;
        u_in  = u;
        v_in  = v;
        @(posedge clk);
        @(negedge clk);
        if (do_reset) begin
            t = 0; anchor = 0; pending = 1'b0;
            check("rst_sample", int'(sample_count), 0);
            check("rst_line", int'(line_count), 0);
            check("rst_even", int'(even_line), 1);
            check("rst_newframe", int'(newframe), 0);
            check("rst_enabled", int'(enabled), 0);
            check("rst_u", int'(yuv_u), 0);
            check("rst_v", int'(yuv_v), 0);
        end else begin
            t++;
            tl = t / CPL;
            if (rs) pending = 1'b1;
            if (t % FRAME == 0) begin
                if (pending) anchor = tl;
                pending = 1'b0;
            end
            s      = t % CPL;
            ln     = tl % LPF;
            chroma = ((ln >= VA) && (ln < VBS)) || (ln >= VBE);
            check("sample", int'(sample_count), s);
            check("line", int'(line_count), ln);
            check("newframe", int'(newframe), int'(t % FRAME == 0));
            check("even", int'(even_line), int'((tl - anchor) % 2 == 0));
            check("enabled", int'(enabled), int'(chroma && s >= CS && s < AE));
            check("yuv_u", int'(yuv_u), (chroma && s >= AS && s < AE) ? int'(u) : 0);
            check("yuv_v", int'(yuv_v), (chroma && s >= AS && s < AE) ? int'(v) : 0);
        end
    endtask

    initial begin
        logic signed [7:0] u, v;
        rs_in = 1'b0; u_in = '0; v_in = '0; rst_n = 1'b0;
        step(1'b1, 1'b0, 8'sd0, 8'sd0);
        step(1'b1, 1'b0, 8'sd0, 8'sd0);

        // Frames 1-2 and part of 3; constant +40/-30 during the first frame, random after.
        while (t < 2 * FRAME + 200 * CPL + 12) begin
            if (t < FRAME) begin
                u = 8'sd40; v = -8'sd30;
            end else begin
                u = 8'($urandom); v = 8'($urandom);
            end
            step(1'b0, (t == FRAME + 400 * CPL), u, v);
            if (t < FRAME && t % CPL == 15) begin
                case (t / CPL)
                    309: check("l309_en", int'(enabled), 1);
                    310: check("l310_en", int'(enabled), 0);
                    335: check("l335_en", int'(enabled), 0);
                    336: check("l336_en", int'(enabled), 1);
                    default: ;
                endcase
            end
            if (t == 23 * CPL + AS) check("l23_u40", int'(yuv_u), 40);
            if (t == 23 * CPL + AS) check("l23_vm30", int'(yuv_v), -30);
            if (t == FRAME) check("f2_l0_even", int'(even_line), 0);
            if (t == FRAME) check("f2_newframe", int'(newframe), 1);
            if (t == 2 * FRAME) check("f3_l0_even_resync", int'(even_line), 1);
        end

        // Mid-frame reset at line 200, then resync asserted exactly on the frame-wrap cycle.
        step(1'b1, 1'b0, 8'sd0, 8'sd0);
        while (t < FRAME + 5) begin
            u = 8'($urandom); v = 8'($urandom);
            step(1'b0, (t == FRAME - 1), u, v);
            if (t == CPL) check("post_rst_l1_even", int'(even_line), 0);
            if (t == FRAME) check("wrap_resync_even", int'(even_line), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
